sync_fifo: RTL and testbench

SYNC_FIFO -- requirements
Module: sync_fifo

---
 rtl/sync_fifo_pkg.sv | 15 +
 rtl/sync_fifo_ram.sv | 23 ++
 rtl/sync_fifo.sv | 128 ++++++++++++
 tb/tb_sync_fifo.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared constants, pointer-width helper and pointer type for the sync_fifo slice.
package sync_fifo_pkg;

  localparam int unsigned DEF_DEPTH  = 16;
  localparam int unsigned DEF_WIDTH  = 8;
  localparam int unsigned DEF_AEMPTY = 2;

  // One extra MSB beyond the address lets equal addresses mean either empty or full.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  typedef logic [ptr_width(DEF_DEPTH)-1:0] ptr_t;

endpackage

// File: rtl/sync_fifo_ram.sv
// Simple dual-port storage for sync_fifo: one write port, one registered read port.
module sync_fifo_ram #(
  parameter int unsigned P_DEPTH = 16,
  parameter int unsigned P_WIDTH = 8,
  parameter int unsigned P_AW    = 4
) (
  input  logic               clk,
  input  logic               wr_en,
  input  logic [P_AW-1:0]    wr_addr,
  input  logic [P_WIDTH-1:0] wr_data,
  input  logic               rd_en,
  input  logic [P_AW-1:0]    rd_addr,
  output logic [P_WIDTH-1:0] rd_data
);

  logic [P_WIDTH-1:0] mem [P_DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO with registered flags and output stage.
// Optional sticky overflow/underflow checks are enabled by defining SYNC_FIFO_ERR_CHK_EN.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int unsigned P_DEPTH  = DEF_DEPTH,
  parameter int unsigned P_WIDTH  = DEF_WIDTH,
  parameter int unsigned P_AFULL  = P_DEPTH - 2,
  parameter int unsigned P_AEMPTY = DEF_AEMPTY
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic [P_WIDTH-1:0]         wr_data,
  input  logic                       wr_vld,
  output logic                       wr_rdy,
  output logic [P_WIDTH-1:0]         rd_data,
  output logic                       rd_vld,
  input  logic                       rd_rdy,
  output logic [$clog2(P_DEPTH):0]   fill,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic                       ovf_err,
  output logic                       udf_err
);

  localparam int unsigned AW = $clog2(P_DEPTH);
  localparam int unsigned PW = ptr_width(P_DEPTH);

  localparam logic [PW-1:0] DEPTH_V  = PW'(P_DEPTH);
  localparam logic [PW-1:0] AFULL_V  = PW'(P_AFULL);
  localparam logic [PW-1:0] AEMPTY_V = PW'(P_AEMPTY);

  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic [PW-1:0]      fill_next;
  logic [P_WIDTH-1:0] ram_q;
  logic               ram_vld;
  logic               push;
  logic               pop;
  logic               mem_empty;
  logic               out_load;
  logic               ram_re;

  assign push      = wr_vld & wr_rdy & ~flush;
  assign pop       = rd_vld & rd_rdy & ~flush;
  assign mem_empty = (wr_ptr == rd_ptr);

  // Two-stage prefetch: RAM read register feeds the output register. A stage
  // may refill on the same edge it is emptied, so streaming has no bubbles.
  assign out_load  = ram_vld & (~rd_vld | pop);
  assign ram_re    = ~mem_empty & (~ram_vld | out_load) & ~flush;

  always_comb begin
    fill_next = fill;
    unique case ({push, pop})
      2'b10:   fill_next = fill + PW'(1);
      2'b01:   fill_next = fill - PW'(1);
      default: fill_next = fill;
    endcase
  end

  sync_fifo_ram #(
    .P_DEPTH (P_DEPTH),
    .P_WIDTH (P_WIDTH),
    .P_AW    (AW)
  ) u_ram (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_data (wr_data),
    .rd_en   (ram_re),
    .rd_addr (rd_ptr[AW-1:0]),
    .rd_data (ram_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      ram_vld      <= 1'b0;
      rd_vld       <= 1'b0;
      rd_data      <= '0;
      fill         <= '0;
      wr_rdy       <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else if (flush) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      ram_vld      <= 1'b0;
      rd_vld       <= 1'b0;
      fill         <= '0;
      wr_rdy       <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      if (push)     wr_ptr  <= wr_ptr + PW'(1);
      if (ram_re)   rd_ptr  <= rd_ptr + PW'(1);
      if (out_load) rd_data <= ram_q;
      ram_vld      <= ram_re | (ram_vld & ~out_load);
      rd_vld       <= out_load | (rd_vld & ~pop);
      fill         <= fill_next;
      wr_rdy       <= (fill_next < DEPTH_V);
      almost_full  <= (fill_next >= AFULL_V);
      almost_empty <= (fill_next <= AEMPTY_V);
    end
  end

`ifdef SYNC_FIFO_ERR_CHK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_err <= 1'b0;
      udf_err <= 1'b0;
    end else if (flush) begin
      ovf_err <= 1'b0;
      udf_err <= 1'b0;
    end else begin
      if (wr_vld & ~wr_rdy) ovf_err <= 1'b1;
      if (rd_rdy & ~rd_vld) udf_err <= 1'b1;
    end
  end
`else
  assign ovf_err = 1'b0;
  assign udf_err = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: directed scenarios plus random traffic
// compared every cycle against a queue-based reference model.
module tb_sync_fifo;

  localparam int unsigned DEPTH  = 16;
  localparam int unsigned WIDTH  = 8;
  localparam int unsigned AFULL  = 14;
  localparam int unsigned AEMPTY = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             flush = 1'b0;
  logic [WIDTH-1:0] wr_data = '0;
  logic             wr_vld = 1'b0;
  logic             wr_rdy;
  logic [WIDTH-1:0] rd_data;
  logic             rd_vld;
  logic             rd_rdy = 1'b0;
  logic [4:0]       fill;
  logic             almost_full;
  logic             almost_empty;
  logic             ovf_err;
  logic             udf_err;

  always #5 clk = ~clk;

  sync_fifo #(
    .P_DEPTH  (DEPTH),
    .P_WIDTH  (WIDTH),
    .P_AFULL  (AFULL),
    .P_AEMPTY (AEMPTY)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .wr_data      (wr_data),
    .wr_vld       (wr_vld),
    .wr_rdy       (wr_rdy),
    .rd_data      (rd_data),
    .rd_vld       (rd_vld),
    .rd_rdy       (rd_rdy),
    .fill         (fill),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .ovf_err      (ovf_err),
    .udf_err      (udf_err)
  );

  // Reference model: stored words with the edge number at which each was pushed.
  logic [WIDTH-1:0] q_data[$];
  int unsigned      q_edge[$];
  int unsigned      edge_no = 0;
  bit               m_ovf = 1'b0;
  bit               m_udf = 1'b0;
  int               n_assert = 0;
  int               n_fail = 0;

  // Head word is visible once two edges have passed since it was pushed.
  function automatic bit m_rd_vld();
    if (q_data.size() == 0) return 1'b0;
    return (edge_no >= q_edge[0] + 2);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    int unsigned sz;
    sz = q_data.size();
    chk("fill",         32'(fill),         32'(sz));
    chk("wr_rdy",       32'(wr_rdy),       32'(sz < DEPTH));
    chk("rd_vld",       32'(rd_vld),       32'(m_rd_vld()));
    chk("almost_full",  32'(almost_full),  32'(sz >= AFULL));
    chk("almost_empty", 32'(almost_empty), 32'(sz <= AEMPTY));
    chk("ovf_err",      32'(ovf_err),      32'(m_ovf));
    chk("udf_err",      32'(udf_err),      32'(m_udf));
    if (m_rd_vld()) chk("rd_data", 32'(rd_data), 32'(q_data[0]));
  endtask

  // One clock: drive inputs, predict, take the edge, then compare.
  task automatic tick(input logic wv, input logic [WIDTH-1:0] wd, input logic rr, input logic fl);
    bit do_push;
    bit do_pop;
    wr_vld  = wv;
    wr_data = wd;
    rd_rdy  = rr;
    flush   = fl;
    do_push = wv && (q_data.size() < DEPTH) && !fl;
    do_pop  = rr && m_rd_vld() && !fl;
`ifdef SYNC_FIFO_ERR_CHK_EN
    if (fl) begin
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      if (wv && !(q_data.size() < DEPTH)) m_ovf = 1'b1;
      if (rr && !m_rd_vld())              m_udf = 1'b1;
    end
`endif
    @(posedge clk);
    edge_no++;
    if (fl) begin
      q_data.delete();
      q_edge.delete();
    end else begin
      if (do_pop) begin
        void'(q_data.pop_front());
        void'(q_edge.pop_front());
      end
      if (do_push) begin
        q_data.push_back(wd);
        q_edge.push_back(edge_no);
      end
    end
    #1;
    check_all();
  endtask

  task automatic reset_pulse();
    rst_n  = 1'b0;
    wr_vld = 1'b0;
    rd_rdy = 1'b0;
    flush  = 1'b0;
    q_data.delete();
    q_edge.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    #1;
    check_all();
    chk("rst_rd_data", 32'(rd_data), 32'h0);
    repeat (2) begin
      @(posedge clk);
      edge_no++;
    end
    #1;
    rst_n = 1'b1;
    check_all();
  endtask

  initial begin
    #2;
    reset_pulse();

    // Single word latency into an empty FIFO.
    tick(1'b1, 8'hA5, 1'b0, 1'b0);
    chk("lat_fill_k", 32'(fill), 32'd1);
    chk("lat_vld_k", 32'(rd_vld), 32'd0);
    tick(1'b0, 8'h00, 1'b0, 1'b0);
    chk("lat_vld_k1", 32'(rd_vld), 32'd0);
    tick(1'b0, 8'h00, 1'b0, 1'b0);
    chk("lat_vld_k2", 32'(rd_vld), 32'd1);
    chk("lat_data_k2", 32'(rd_data), 32'hA5);
    tick(1'b0, 8'h00, 1'b1, 1'b0);

    // Fill to capacity, attempt overflow, drain in order, attempt underflow.
    for (int i = 1; i <= 16; i++) tick(1'b1, 8'(i), 1'b0, 1'b0);
    chk("full_fill", 32'(fill), 32'd16);
    chk("full_wr_rdy", 32'(wr_rdy), 32'd0);
    tick(1'b1, 8'hEE, 1'b0, 1'b0);
    tick(1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 40 && q_data.size() > 0; i++) tick(1'b0, 8'h00, 1'b1, 1'b0);
    chk("drain_empty", 32'(fill), 32'd0);
    tick(1'b0, 8'h00, 1'b1, 1'b0);
    tick(1'b0, 8'h00, 1'b0, 1'b0);
    tick(1'b0, 8'h00, 1'b0, 1'b1);

    // Sustained simultaneous push and pop at fill=8.
    for (int i = 0; i < 8; i++) tick(1'b1, 8'($urandom), 1'b0, 1'b0);
    tick(1'b0, 8'h00, 1'b0, 1'b0);
    tick(1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 100; i++) tick(1'b1, 8'($urandom), 1'b1, 1'b0);
    chk("stream_fill", 32'(fill), 32'd8);

    // Flush at fill=5 together with a push and a pop.
    for (int i = 0; i < 3; i++) tick(1'b0, 8'h00, 1'b1, 1'b0);
    chk("pre_flush_fill", 32'(fill), 32'd5);
    tick(1'b1, 8'h77, 1'b1, 1'b1);
    tick(1'b1, 8'h3C, 1'b0, 1'b0);
    tick(1'b0, 8'h00, 1'b0, 1'b0);
    tick(1'b0, 8'h00, 1'b0, 1'b0);
    chk("post_flush_head", 32'(rd_data), 32'h3C);

    // Random traffic with occasional flush.
    for (int i = 0; i < 400; i++)
      tick(1'($urandom), 8'($urandom), 1'($urandom), ($urandom_range(0, 39) == 0));

    // Asynchronous reset in the middle of a burst at fill=9.
    tick(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) tick(1'b1, 8'($urandom), 1'b0, 1'b0);
    chk("pre_rst_fill", 32'(fill), 32'd9);
    #2;
    reset_pulse();
    for (int i = 0; i < 40; i++)
      tick(1'($urandom), 8'($urandom), 1'($urandom), 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
